cache_fill_responder: RTL
=========================

Name: cache_fill_responder

Overview:
Memory-side end of the cache line-fill handshake. Accepts a fill request from the two-way cache (req level plus word address), issues one 4-word wrapped burst read to the SDRAM controller port, and buffers the returned words. It then replays them to the cache as a gap-free 4-cycle burst, critical word first, with a single-cycle fill strobe. It sits between the cache's sdram_req/sdram_fill/data_from_sdram pins and the SDRAM controller's read port.

Parameters:
ADDR_W, 25, width of word address (byte address bits [ADDR_W:1])

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cache_req  in  1  level fill request from cache; held until the fill strobe
cache_addr  in  ADDR_W  word address of the missed word; [1:0] is the critical-word index
cache_fill  out  1  one-cycle strobe marking the first burst word on cache_data
cache_data  out  16  burst data to cache
mem_req  out  1  burst read request to SDRAM controller
mem_addr  out  ADDR_W  {line address, critical index}; memory returns wrapped order
mem_ack  in  1  controller accepted mem_req (one cycle)
mem_rdata  in  16  read data
mem_rvalid  in  1  mem_rdata valid; gaps allowed between words
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE; cache_fill=0, cache_data=0, mem_req=0, mem_addr=0, busy=0; word counter=0; discard flag=0. Buffer contents are don't-care.
- States: IDLE, ISSUE, COLLECT, STREAM.
- IDLE: when cache_req=1, latch cache_addr into mem_addr, set mem_req=1, go to ISSUE. Requests are registered, so mem_req rises the cycle after cache_req is sampled. mem_rvalid is ignored in IDLE.
- ISSUE: hold mem_req and mem_addr stable until mem_ack=1. On the ack cycle, mem_req drops the next cycle and the state goes to COLLECT.
- COLLECT: each mem_rvalid=1 writes mem_rdata to buf[cnt], cnt=cnt+1 (3-bit). The buffer therefore holds words in delivery order: buf[0] is the critical word, buf[k] is word (crit+k) mod 4. If mem_rvalid coincides with the ack cycle in ISSUE, that word is captured too.
- Leaving COLLECT: on the cycle the 4th word is captured, go to STREAM with index=0, unless discard=1, in which case return to IDLE.
- STREAM: lasts exactly 4 cycles, index 0..3.
  - cache_data=buf[index] on each cycle (registered output).
  - cache_fill=1 only on index 0.
  - After index 3, go to IDLE; cache_data holds its last value.
  - Latency: the first word reaches cache_fill/cache_data 1 cycle after the 4th mem_rvalid.
  - Minimum miss latency with 1-cycle mem_ack and back-to-back rvalid is 7 cycles from cache_req sampled high.
- Abort: if cache_req falls while in ISSUE or COLLECT, set discard=1. The memory transaction still completes (mem_req is never withdrawn before ack), but no fill is produced. discard clears on entry to IDLE.
- mem_rvalid beyond 4 words, or in STREAM/IDLE, is ignored. It must not alter buf or cnt.
- No new request is accepted until IDLE. cache_req still high on the first IDLE cycle after STREAM starts a new request; the cache guarantees this does not happen for a completed fill.
- Critical-word order wraps modulo 4 (crit=2 gives delivery order 2,3,0,1), matching the cache's 2-bit readword increment.
- Reset asserted mid-burst: immediate return to IDLE with all outputs 0. Partial buffer data is never emitted.

Test Plan:
- Reset then idle: reset_n low, mem_rvalid pulsed -> all outputs 0, busy=0, no state change after release.
- Basic fill: cache_addr=0x0001235, mem_ack 1 cycle after mem_req, rvalid words 0xA000..0xA003 back-to-back -> mem_addr=0x0001235; cache_fill high for 1 cycle; cache_data=0xA000,0xA001,0xA002,0xA003 on 4 consecutive cycles starting 1 cycle after the last rvalid.
- Gapped return and ack delay: mem_ack delayed 5 cycles, rvalid with 0/3/1-cycle gaps -> mem_req stable until ack; output burst still contiguous, same order as delivered.
- Abort: cache_req dropped during COLLECT after 2 words -> remaining 2 words absorbed; cache_fill never asserts; busy falls; next request served normally.
- Spurious and extra valids: 5th rvalid during STREAM and rvalid in IDLE -> cache_data sequence unchanged; cnt not advanced.
- Async reset mid-STREAM at index 1 -> outputs 0 within the reset; no further fill words; clean IDLE after release.

Source files
------------

// File: rtl/cache_fill_responder.sv
// cache_fill_responder
// Memory-side end of the cache line-fill handshake. It issues one wrapped
// 4-word burst read and buffers the words in delivery order, so buffer slot 0
// holds the critical word. It then replays the words to the cache as a
// gap-free 4-cycle burst with a one-cycle fill strobe on the first word.

module cache_fill_responder #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_fill,
  output logic [15:0]       cache_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_STREAM  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              cache_fill_q, cache_fill_d;
  logic [15:0]       cache_data_q, cache_data_d;
  logic              busy_q, busy_d;
  logic [15:0]       line_buf_q [4];
  logic              wr_en_s;
  logic [1:0]        wr_idx_s;

  assign cache_fill = cache_fill_q;
  assign cache_data = cache_data_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign wr_idx_s   = cnt_q[1:0];

  // Next-state and registered-output computation for the fill handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    discard_d    = discard_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    cache_fill_d = 1'b0;
    cache_data_d = cache_data_q;
    wr_en_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = 3'd0;
        idx_d     = 2'd0;
        discard_d = 1'b0;
        if (cache_req) begin
          mem_addr_d = cache_addr;
          mem_req_d  = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          mem_req_d = 1'b0;
        end
      end

      ST_ISSUE: begin
        // The request is never withdrawn; a dropped cache_req only marks the
        // transaction for discard.
        if (!cache_req) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_COLLECT;
          // A word arriving together with the ack is the critical word.
          if (mem_rvalid) begin
            wr_en_s = 1'b1;
            cnt_d   = cnt_q + 3'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (!cache_req) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (mem_rvalid) begin
          wr_en_s = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            if (discard_q || !cache_req) begin
              discard_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              // Slot 0 was filled earlier, so the critical word can be
              // launched on the same edge that captures the last word.
              state_d      = ST_STREAM;
              idx_d        = 2'd0;
              cache_fill_d = 1'b1;
              cache_data_d = line_buf_q[0];
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_STREAM: begin
        if (idx_q == 2'd3) begin
          // Last word stays on cache_data after the burst.
          state_d = ST_IDLE;
        end else begin
          idx_d        = idx_q + 2'd1;
          cache_data_d = line_buf_q[idx_q + 2'd1];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      idx_q        <= 2'd0;
      discard_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      cache_fill_q <= 1'b0;
      cache_data_q <= 16'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      discard_q    <= discard_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      cache_fill_q <= cache_fill_d;
      cache_data_q <= cache_data_d;
      busy_q       <= busy_d;
    end
  end

  // Line buffer, written in delivery order (slot 0 = critical word).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        line_buf_q[i] <= 16'd0;
      end
    end else if (wr_en_s) begin
      line_buf_q[wr_idx_s] <= mem_rdata;
    end
  end

endmodule
